// File: rtl/sap_core_param.sv
// sap_core_param: parametrised SAP core (PC, MAR, IR, A, B, ALU, RAM, microsequencer) sharing one internal bus.
// Define SAP_CALL_EN to add CALL (opcode A) / RET (opcode B) with a single-level return register.

module sap_core_param #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 4,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              halted,
   output logic [ADDR_W-1:0] dbg_pc
);

   localparam int              DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_T0       = 3'd1;
   localparam logic [2:0] S_T1       = 3'd2;
   localparam logic [2:0] S_T2       = 3'd3;
   localparam logic [2:0] S_T3       = 3'd4;
   localparam logic [2:0] S_T4       = 3'd5;
   localparam logic [2:0] S_OUT_WAIT = 3'd6;
   localparam logic [2:0] S_HALT     = 3'd7;

   localparam logic [3:0] OP_LDA  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_STA  = 4'h4;
   localparam logic [3:0] OP_LDI  = 4'h5;
   localparam logic [3:0] OP_JMP  = 4'h6;
   localparam logic [3:0] OP_JC   = 4'h7;
   localparam logic [3:0] OP_JZ   = 4'h8;
   localparam logic [3:0] OP_OUT  = 4'hE;
   localparam logic [3:0] OP_HLT  = 4'hF;
`ifdef SAP_CALL_EN
   localparam logic [3:0] OP_CALL = 4'hA;
   localparam logic [3:0] OP_RET  = 4'hB;
`endif

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic              c_q, c_d;
   logic              z_q, z_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
`ifdef SAP_CALL_EN
   logic [ADDR_W-1:0] ret_q, ret_d;
`endif

   // NOTE: program RAM has no reset; contents must survive rst, and it maps onto plain RAM macros.
   logic [DATA_W-1:0] mem [DEPTH];

   logic [3:0]        opcode;
   logic [ADDR_W-1:0] operand;
   logic [DATA_W-1:0] pc_ext, operand_ext;
   logic [DATA_W-1:0] mem_rd;
   logic [DATA_W-1:0] bus;
   logic [DATA_W:0]   alu_sum, alu_diff;
   logic [DATA_W-1:0] alu_res;
   logic              alu_c;
   logic              takes_operand;
   logic              sta_we;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   assign opcode      = ir_q[DATA_W-1 -: 4];
   assign operand     = ir_q[ADDR_W-1:0];
   assign pc_ext      = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
   assign operand_ext = {{(DATA_W-ADDR_W){1'b0}}, operand};
   assign mem_rd      = mem[mar_q];

   // The sum/difference carry one extra bit so carry-out and borrow fall out directly.
   assign alu_sum  = {1'b0, a_q} + {1'b0, b_q};
   assign alu_diff = {1'b0, a_q} - {1'b0, b_q};

   always_comb begin
      if (opcode == OP_SUB) begin
         alu_res = alu_diff[DATA_W-1:0];
         alu_c   = ~alu_diff[DATA_W];
      end else begin
         alu_res = alu_sum[DATA_W-1:0];
         alu_c   = alu_sum[DATA_W];
      end
   end

   always_comb begin
      case (opcode)
         OP_LDA, OP_ADD, OP_SUB, OP_STA,
         OP_LDI, OP_JMP, OP_JC, OP_JZ: takes_operand = 1'b1;
`ifdef SAP_CALL_EN
         OP_CALL:                      takes_operand = 1'b1;
`endif
         default:                      takes_operand = 1'b0;
      endcase
   end

   // Single-driver internal bus; idle cycles drive zero.
   always_comb begin
      bus = '0;
      case (state_q)
         S_T0: bus = pc_ext;
         S_T1: bus = mem_rd;
         S_T2: begin
            if (opcode == OP_OUT) bus = a_q;
            else if (takes_operand) bus = operand_ext;
         end
         S_T3: bus = (opcode == OP_STA) ? a_q : mem_rd;
         S_T4: bus = alu_res;
         default: bus = '0;
      endcase
   end

   // NOTE: every signal assigned here gets a default first, otherwise synthesis infers latches.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      mar_d       = mar_q;
      ir_d        = ir_q;
      a_d         = a_q;
      b_d         = b_q;
      c_d         = c_q;
      z_d         = z_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      sta_we      = 1'b0;
`ifdef SAP_CALL_EN
      ret_d       = ret_q;
`endif
      case (state_q)
         S_IDLE: if (run) state_d = S_T0;
         S_T0: begin
            mar_d   = bus[ADDR_W-1:0];
            state_d = S_T1;
         end
         S_T1: begin
            ir_d    = bus;
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_T2;
         end
         S_T2: begin
            state_d = S_T0;
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  mar_d   = bus[ADDR_W-1:0];
                  state_d = S_T3;
               end
               OP_LDI: a_d = bus;
               OP_JMP: pc_d = bus[ADDR_W-1:0];
               OP_JC:  if (c_q) pc_d = bus[ADDR_W-1:0];
               OP_JZ:  if (z_q) pc_d = bus[ADDR_W-1:0];
               OP_OUT: begin
                  out_data_d  = bus;
                  out_valid_d = 1'b1;
                  state_d     = S_OUT_WAIT;
               end
               OP_HLT: state_d = S_HALT;
`ifdef SAP_CALL_EN
               OP_CALL: begin
                  ret_d = pc_q;
                  pc_d  = bus[ADDR_W-1:0];
               end
               OP_RET: pc_d = ret_q;
`endif
               default: ;
            endcase
         end
         S_T3: begin
            state_d = S_T0;
            case (opcode)
               OP_LDA: a_d = bus;
               OP_STA: sta_we = 1'b1;
               default: begin
                  b_d     = bus;
                  state_d = S_T4;
               end
            endcase
         end
         S_T4: begin
            a_d     = bus;
            z_d     = (bus == '0);
            c_d     = alu_c;
            state_d = S_T0;
         end
         S_OUT_WAIT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_T0;
            end
         end
         S_HALT: ;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pc_q        <= PC_INIT;
         mar_q       <= '0;
         ir_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= 1'b0;
         z_q         <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         mar_q       <= mar_d;
         ir_q        <= ir_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         z_q         <= z_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

`ifdef SAP_CALL_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ret_q <= '0;
      else     ret_q <= ret_d;
   end
`endif

   // Reset forces IDLE asynchronously, so an interrupted STA can never complete its write.
   assign mem_we    = ((state_q == S_IDLE) && prog_we) || sta_we;
   assign mem_waddr = sta_we ? mar_q : prog_addr;
   assign mem_wdata = sta_we ? bus : prog_data;

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
   assign halted    = (state_q == S_HALT);
   assign dbg_pc    = pc_q;

endmodule
